// File: rtl/ahb_master_if.sv
// ahb_master_if: single-master AHB-Lite burst engine (request/grant, pipelined INCR words, wait/ERROR/RETRY/SPLIT)
// Ports:
//   HCLK, HRESETn                      bus clock, async active-low reset
//   cmd_valid/ready/addr/write/beats/lock  local burst command (accepted only in IDLE)
//   wdata, wdata_ack                   write word for the next beat, pulsed when captured
//   rdata, rdata_valid                 read word, pulsed per OKAY read beat
//   done, err                          burst completed OKAY / aborted by ERROR
//   HBUSREQ, HLOCK, HGRANT             arbiter handshake
//   HREADY, HRESP, HRDATA              slave response
//   HADDR, HTRANS, HWRITE, HWDATA, HSIZE, HBURST  registered bus outputs
module ahb_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_write,
   input  logic [4:0]        cmd_beats,
   input  logic              cmd_lock,
   input  logic [DATA_W-1:0] wdata,
   output logic              wdata_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              done,
   output logic              err,
   output logic              HBUSREQ,
   output logic              HLOCK,
   input  logic              HGRANT,
   input  logic              HREADY,
   input  logic [1:0]        HRESP,
   input  logic [DATA_W-1:0] HRDATA,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [DATA_W-1:0] HWDATA,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST
);
   typedef enum logic [2:0] {IDLE, REQ, XFER, DRAIN, RESP2} state_t;
   localparam logic [1:0] T_IDLE = 2'b00, T_NSEQ = 2'b10, T_SEQ = 2'b11;
   localparam logic [1:0] R_OKAY = 2'b00, R_ERROR = 2'b01;
   localparam logic [ADDR_W-1:0] INC = ADDR_W'(DATA_W / 8);
   state_t state;
   logic [ADDR_W-1:0] addr, dp_addr;
   logic [4:0] addr_left, data_left, beats;
   logic dp_valid, lock, reuse;
   assign beats = (cmd_beats == 5'd0) ? 5'd1 : cmd_beats;
   assign cmd_ready = (state == IDLE);
   assign HSIZE = 3'($clog2(DATA_W / 8));
   assign HBURST = 3'b001;
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state       <= IDLE;
         addr        <= '0;
         dp_addr     <= '0;
         addr_left   <= '0;
         data_left   <= '0;
         dp_valid    <= 1'b0;
         lock        <= 1'b0;
         reuse       <= 1'b0;
         HADDR       <= '0;
         HTRANS      <= T_IDLE;
         HWRITE      <= 1'b0;
         HWDATA      <= '0;
         HBUSREQ     <= 1'b0;
         HLOCK       <= 1'b0;
         rdata       <= '0;
         wdata_ack   <= 1'b0;
         rdata_valid <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         wdata_ack   <= 1'b0;
         rdata_valid <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         case (state)
            IDLE: if (cmd_valid) begin
               addr      <= cmd_addr;
               HWRITE    <= cmd_write;
               lock      <= cmd_lock;
               addr_left <= beats;
               data_left <= beats;
               HBUSREQ   <= 1'b1;
               HLOCK     <= cmd_lock;
               reuse     <= 1'b0;
               state     <= REQ;
            end
            // second response cycle: ERROR aborts, RETRY/SPLIT rewinds to the failed beat
            RESP2: if (HREADY) begin
               dp_valid <= 1'b0;
               if (HRESP == R_ERROR) begin
                  err     <= 1'b1;
                  HBUSREQ <= 1'b0;
                  HLOCK   <= 1'b0;
                  state   <= IDLE;
               end else begin
                  addr      <= dp_addr;
                  addr_left <= data_left;
                  HBUSREQ   <= 1'b1;
                  HLOCK     <= lock;
                  reuse     <= HWRITE;
                  state     <= REQ;
               end
            end
            default: if (dp_valid && !HREADY && HRESP != R_OKAY) begin
               // first response cycle: cancel the pipelined address at once
               HTRANS <= T_IDLE;
               state  <= RESP2;
            end else if (HREADY) begin
               dp_valid <= 1'b0;
               if (dp_valid) data_left <= data_left - 5'd1;
               if (dp_valid && !HWRITE) begin
                  rdata       <= HRDATA;
                  rdata_valid <= 1'b1;
               end
               if (state == REQ && HGRANT) begin
                  state  <= XFER;
                  HTRANS <= T_NSEQ;
                  HADDR  <= addr;
               end
               if (state == XFER) begin
                  dp_valid  <= 1'b1;
                  dp_addr   <= HADDR;
                  addr_left <= addr_left - 5'd1;
                  addr      <= HADDR + INC;
                  reuse     <= 1'b0;
                  // a retried write beat keeps the word already on HWDATA
                  if (HWRITE && !reuse) begin
                     HWDATA    <= wdata;
                     wdata_ack <= 1'b1;
                  end
                  if (addr_left == 5'd1) begin
                     state   <= DRAIN;
                     HTRANS  <= T_IDLE;
                     HBUSREQ <= 1'b0;
                     HLOCK   <= 1'b0;
                  end else if (!HGRANT) begin
                     state  <= REQ;
                     HTRANS <= T_IDLE;
                  end else begin
                     HTRANS <= T_SEQ;
                     HADDR  <= HADDR + INC;
                  end
               end
               if (dp_valid && data_left == 5'd1) begin
                  done    <= 1'b1;
                  state   <= IDLE;
                  HTRANS  <= T_IDLE;
                  HBUSREQ <= 1'b0;
                  HLOCK   <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule
